// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity, 1 or 2 stop bits, back-to-back frames supported.
module uart_tx_cfg #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        baud_cnt, baud_nx;
    logic [3:0]           bit_idx, bit_idx_nx;
    logic [DATA_BITS-1:0] shift_reg, shift_nx;
    logic                 par_bit, par_nx;
    logic                 tx_nx, busy_nx;
    logic                 bit_end, handshake;

    assign bit_end   = (baud_cnt == BAUD_LAST);
    // ready depends only on registered state so it never loops back through valid
    assign ready     = (state == ST_IDLE) ||
                       ((state == ST_STOP) && bit_end && (bit_idx == STOP_LAST));
    assign handshake = valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            baud_cnt  <= baud_nx;
            bit_idx   <= bit_idx_nx;
            shift_reg <= shift_nx;
            par_bit   <= par_nx;
            tx        <= tx_nx;
            busy      <= busy_nx;
        end
    end

    // tx is registered, so each branch computes the line value for the next cycle
    always_comb begin
        state_nx   = state;
        baud_nx    = bit_end ? '0 : baud_cnt + 1'b1;
        bit_idx_nx = bit_idx;
        shift_nx   = shift_reg;
        par_nx     = par_bit;
        tx_nx      = tx;
        busy_nx    = busy;

        case (state)
            ST_IDLE: begin
                baud_nx    = '0;
                bit_idx_nx = '0;
            end
            ST_START: begin
                if (bit_end) begin
                    state_nx   = ST_DATA;
                    bit_idx_nx = '0;
                    tx_nx      = shift_reg[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_nx = shift_reg >> 1;
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_nx = '0;
                        if (PARITY != 0) begin
                            state_nx = ST_PARITY;
                            tx_nx    = par_bit;
                        end else begin
                            state_nx = ST_STOP;
                            tx_nx    = 1'b1;
                        end
                    end else begin
                        bit_idx_nx = bit_idx + 4'd1;
                        tx_nx      = shift_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_nx   = ST_STOP;
                    bit_idx_nx = '0;
                    tx_nx      = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        state_nx   = ST_IDLE;
                        bit_idx_nx = '0;
                        tx_nx      = 1'b1;
                        busy_nx    = 1'b0;
                    end else begin
                        bit_idx_nx = bit_idx + 4'd1;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                tx_nx    = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase

        // A handshake in IDLE or the last stop cycle overrides the normal flow
        if (handshake) begin
            state_nx   = ST_START;
            baud_nx    = '0;
            bit_idx_nx = '0;
            shift_nx   = data;
            par_nx     = (PARITY == 1) ? ~(^data) : ^data;
            tx_nx      = 1'b0;
            busy_nx    = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: five differently configured instances
// checked cycle by cycle against a frame-level model of the serial line.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] valid_v, tx_v, ready_v, busy_v;
    logic [8:0] data_v [5];

    int cfg_db  [5] = '{8, 8, 8, 7, 9};
    int cfg_cpb [5] = '{4, 4, 4, 4, 1};
    int cfg_par [5] = '{0, 2, 1, 0, 1};
    int cfg_sb  [5] = '{1, 1, 1, 2, 2};

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   exp_tx[$], exp_rdy[$];
    logic obs_tx[$], obs_rdy[$], obs_busy[$];

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .data(data_v[0][7:0]), .valid(valid_v[0]),
        .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .data(data_v[1][7:0]), .valid(valid_v[1]),
        .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .data(data_v[2][7:0]), .valid(valid_v[2]),
        .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));
    uart_tx_cfg #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .data(data_v[3][6:0]), .valid(valid_v[3]),
        .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]));
    uart_tx_cfg #(.DATA_BITS(9), .CLKS_PER_BIT(1), .PARITY(1), .STOP_BITS(2)) u4 (
        .clk(clk), .rst_n(rst_n), .data(data_v[4]), .valid(valid_v[4]),
        .ready(ready_v[4]), .tx(tx_v[4]), .busy(busy_v[4]));

    function automatic void clear_q();
        exp_tx.delete(); exp_rdy.delete();
        obs_tx.delete(); obs_rdy.delete(); obs_busy.delete();
    endfunction

    // Line model: list the frame's bits, then stretch each to cfg_cpb cycles
    function automatic void model_frame(input int inst, input logic [8:0] d);
        bit bits[$];
        int ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < cfg_db[inst]; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (cfg_par[inst] == 2) bits.push_back((ones % 2) == 1);
        if (cfg_par[inst] == 1) bits.push_back((ones % 2) == 0);
        for (int i = 0; i < cfg_sb[inst]; i++) bits.push_back(1'b1);
        foreach (bits[b])
            for (int c = 0; c < cfg_cpb[inst]; c++) begin
                exp_tx.push_back(bits[b]);
                exp_rdy.push_back((b == bits.size() - 1) && (c == cfg_cpb[inst] - 1));
            end
    endfunction

    function automatic int frame_len(input int inst);
        return (1 + cfg_db[inst] + ((cfg_par[inst] != 0) ? 1 : 0) + cfg_sb[inst]) * cfg_cpb[inst];
    endfunction

    // Caller drives valid/data at a negedge; records n cycles while jittering the
    // inputs, then drives nv/nd during the final stop cycle.
    task automatic run_frame(input int inst, input int n, input logic nv, input logic [8:0] nd);
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            obs_tx.push_back(tx_v[inst]);
            obs_rdy.push_back(ready_v[inst]);
            obs_busy.push_back(busy_v[inst]);
            if (k < n - 1) begin
                valid_v[inst] = 1'($urandom);
                data_v[inst]  = 9'($urandom);
            end else begin
                valid_v[inst] = nv;
                data_v[inst]  = nd;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_v = '0;
        for (int i = 0; i < 5; i++) data_v[i] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({tx_v[i], ready_v[i], busy_v[i]} !== 3'b110) begin
                n_bad++;
                $display("[TB] FAIL reset inst%0d: tx/ready/busy got %b%b%b want 110",
                         i, tx_v[i], ready_v[i], busy_v[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({tx_v[0], ready_v[0], busy_v[0]} !== 3'b110) begin
                n_bad++;
                $display("[TB] FAIL idle cycle %0d: tx/ready/busy got %b%b%b want 110",
                         k, tx_v[0], ready_v[0], busy_v[0]);
            end
        end
    endtask

    task automatic test_frame(input string name, input int inst, input logic [8:0] d);
        clear_q();
        model_frame(inst, d);
        valid_v[inst] = 1'b1;
        data_v[inst]  = d;
        run_frame(inst, frame_len(inst), 1'b0, 9'h0);
        for (int k = 0; k < exp_tx.size(); k++) begin
            n_cmp++;
            if (obs_tx[k] !== exp_tx[k] || obs_rdy[k] !== exp_rdy[k] || obs_busy[k] !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL %s cycle %0d: tx/ready/busy got %b%b%b want %b%b1",
                         name, k, obs_tx[k], obs_rdy[k], obs_busy[k], exp_tx[k], exp_rdy[k]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({tx_v[inst], ready_v[inst], busy_v[inst]} !== 3'b110) begin
            n_bad++;
            $display("[TB] FAIL %s end: tx/ready/busy got %b%b%b want 110",
                     name, tx_v[inst], ready_v[inst], busy_v[inst]);
        end
    endtask

    task automatic test_parity();
        test_frame("even_parity", 1, 9'h003);
        n_cmp++;
        if (obs_tx[37] !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL even_parity_bit: got %b want 0", obs_tx[37]);
        end
        test_frame("odd_parity", 2, 9'h003);
        n_cmp++;
        if (obs_tx[37] !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL odd_parity_bit: got %b want 1", obs_tx[37]);
        end
    endtask

    task automatic test_back_to_back(input string name, input int inst,
                                     input logic [8:0] d1, input logic [8:0] d2);
        clear_q();
        model_frame(inst, d1);
        model_frame(inst, d2);
        valid_v[inst] = 1'b1;
        data_v[inst]  = d1;
        run_frame(inst, frame_len(inst), 1'b1, d2);
        run_frame(inst, frame_len(inst), 1'b0, 9'h0);
        for (int k = 0; k < exp_tx.size(); k++) begin
            n_cmp++;
            if (obs_tx[k] !== exp_tx[k] || obs_rdy[k] !== exp_rdy[k] || obs_busy[k] !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL %s cycle %0d: tx/ready/busy got %b%b%b want %b%b1",
                         name, k, obs_tx[k], obs_rdy[k], obs_busy[k], exp_tx[k], exp_rdy[k]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({tx_v[inst], ready_v[inst], busy_v[inst]} !== 3'b110) begin
            n_bad++;
            $display("[TB] FAIL %s end: tx/ready/busy got %b%b%b want 110",
                     name, tx_v[inst], ready_v[inst], busy_v[inst]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int inst;
            inst = int'($urandom_range(0, 4));
            test_frame("random", inst, 9'($urandom));
        end
        for (int it = 0; it < 3; it++)
            test_back_to_back("random_b2b_cpb1", 4, 9'($urandom), 9'($urandom));
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] d;
        d = 9'($urandom) & 9'h0F7;
        valid_v[0] = 1'b1;
        data_v[0]  = d;
        @(posedge clk);
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (16) @(negedge clk);
        n_cmp++;
        if ({tx_v[0], busy_v[0]} !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL data_bit3 before reset: tx/busy got %b%b want 01", tx_v[0], busy_v[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tx_v[0], ready_v[0], busy_v[0]} !== 3'b110) begin
            n_bad++;
            $display("[TB] FAIL async_reset: tx/ready/busy got %b%b%b want 110",
                     tx_v[0], ready_v[0], busy_v[0]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        test_frame("after_reset", 0, 9'($urandom));
    endtask

    initial begin
        $display("[TB] uart_tx_cfg bench start");
        test_reset();
        test_idle();
        test_frame("frame_55", 0, 9'h055);
        test_parity();
        test_frame("stop2_7f", 3, 9'h07F);
        test_back_to_back("b2b_a5_3c", 0, 9'h0A5, 9'h03C);
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
